fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter / fetch stage of the 9-bit single-cycle core; drives ProgCtr to instruction ROM.
//  Consumes BranchEn and Halt from the control decoder plus the ALU Equal flag.
//  Sequences program start/hold, PC increment, PC-relative taken branches and halt; raises Ack when done.
// PARAMETERS
//  PCW        10   program counter width (ROM depth 2**PCW)
//  OFFW       5    branch offset width (signed, two's complement, = Instruction[4:0])
//  START_ADDR 0    PC value loaded on Reset and on Start
// PORTS
//  Clk       in   1     single clock; all state updates on rising edge
//  Reset     in   1     synchronous, active-high reset
//  Start     in   1     level; hold core while high, run from START_ADDR on release
//  BranchEn  in   1     decoder: current instruction is a conditional branch
//  Equal     in   1     ALU flag; branch taken when BranchEn && Equal
//  Offset    in   OFFW  signed PC-relative branch displacement
//  Halt      in   1     decoder: current instruction is halt
//  ProgCtr   out  PCW   address of current instruction (registered)
//  Running   out  1     high in RUN state only
//  Ack       out  1     high in HALT state (program complete)
// BEHAVIOUR
//  States: IDLE, RUN, HALT (2-bit encoded register). Priority: Reset > Start > Halt > branch > increment.
//  Reset (sync): state=IDLE, ProgCtr=START_ADDR, Running=0, Ack=0; applies mid-program, any state.
//  IDLE: ProgCtr held at START_ADDR; Start high -> stay IDLE; Start low -> RUN next edge.
//  RUN, per edge:
//   - Start high -> IDLE, ProgCtr=START_ADDR (restart).
//   - Halt high -> HALT, ProgCtr unchanged (halt wins over simultaneous BranchEn).
//   - BranchEn && Equal -> ProgCtr = ProgCtr + sext(Offset), modulo 2**PCW.
//   - BranchEn && !Equal, or no branch -> ProgCtr = ProgCtr + 1, modulo 2**PCW.
//  HALT: ProgCtr frozen; Ack=1; stays until Start high (-> IDLE, ProgCtr=START_ADDR) or Reset.
//  Decoder inputs (BranchEn, Halt) are ignored outside RUN.
//  Latency: one cycle from any decision to new ProgCtr; first fetch at START_ADDR on the
//   first RUN cycle (cycle after Start falls). Offset 0 taken -> self-loop (legal).
//  Wrap-around: PC add is PCW-bit, carries/borrows discarded (PC 2**PCW-1 + 1 -> 0; 0 + (-1) -> max).
//  Running and Ack are decoded combinationally from the state register; never both high.
//  Unknown/illegal state encoding -> IDLE on next edge.
// CONFIGURATION
//  Macro FETCH_CYCLE_COUNT_EN:
//   defined: adds output CycleCount [15:0]; cleared by Reset and on entry to IDLE;
//    increments every RUN cycle, saturates at 16'hFFFF; frozen in HALT for readback.
//   undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset high 2 cycles, Start high 3 cycles then low -> ProgCtr=0 through IDLE, Running=1
//    first cycle after Start falls, ProgCtr 0,1,2,3 on successive edges.
//  2 RUN at PC=8, BranchEn=1 Equal=1 Offset=5'b11101 (-3) -> next PC=5; repeat with Equal=0 -> PC=9.
//  3 PC=2**PCW-1 straight-line -> PC=0; PC=0 taken branch Offset=-1 -> PC=2**PCW-1.
//  4 PC=20, Halt=1 with BranchEn=1 Equal=1 -> Ack=1, Running=0, PC stays 20 for 10 cycles;
//    then Start pulse -> IDLE, PC=START_ADDR, Ack=0.
//  5 Reset asserted mid-RUN at PC=37 -> next edge ProgCtr=START_ADDR, state IDLE, Ack=0.
//  6 FETCH_CYCLE_COUNT_EN: run 12 cycles then Halt -> CycleCount=12 held in HALT;
//    Start pulse -> 0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/fetch stage: start/hold, increment, PC-relative branch, halt.
// Optional cycle counter output enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_unit #(
  parameter int             PCW        = 10,
  parameter int             OFFW       = 5,
  parameter logic [PCW-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            BranchEn,
  input  logic            Equal,
  input  logic [OFFW-1:0] Offset,
  input  logic            Halt,
  output logic [PCW-1:0]  ProgCtr,
  output logic            Running,
  output logic            Ack
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]     CycleCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [PCW-1:0] next_pc;
  logic [PCW-1:0] offset_ext;
  logic [PCW-1:0] pc_inc;

  // Sign-extend to PC width so the add wraps modulo 2**PCW in both directions.
  assign offset_ext = {{(PCW-OFFW){Offset[OFFW-1]}}, Offset};
  assign pc_inc     = ProgCtr + {{(PCW-1){1'b0}}, 1'b1};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= START_ADDR;
    end else begin
      state   <= next_state;
      ProgCtr <= next_pc;
    end
  end

  always_comb begin
    next_state = state;
    next_pc    = ProgCtr;
    case (state)
      IDLE: begin
        next_pc = START_ADDR;
        if (!Start) next_state = RUN;
      end
      RUN: begin
        if (Start) begin
          next_state = IDLE;
          next_pc    = START_ADDR;
        end else if (Halt) begin
          next_state = HALT;
        end else if (BranchEn && Equal) begin
          next_pc = ProgCtr + offset_ext;
        end else begin
          next_pc = pc_inc;
        end
      end
      HALT: begin
        if (Start) begin
          next_state = IDLE;
          next_pc    = START_ADDR;
        end
      end
      default: begin
        next_state = IDLE;
        next_pc    = START_ADDR;
      end
    endcase
  end

  assign Running = (state == RUN);
  assign Ack     = (state == HALT);

`ifdef FETCH_CYCLE_COUNT_EN
  // Counts edges taken while in RUN, so the halting cycle is included.
  always_ff @(posedge Clk) begin
    if (Reset || next_state == IDLE) begin
      CycleCount <= '0;
    end else if (state == RUN && CycleCount != 16'hFFFF) begin
      CycleCount <= CycleCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, BranchEn, Equal, Halt;
  logic [4:0] Offset;
  logic [9:0] ProgCtr;
  logic       Running, Ack;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] CycleCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .BranchEn (BranchEn),
    .Equal    (Equal),
    .Offset   (Offset),
    .Halt     (Halt),
    .ProgCtr  (ProgCtr),
    .Running  (Running),
    .Ack      (Ack)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .CycleCount (CycleCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [9:0] pc, input logic run, input logic ack);
    check({tag, ".pc"}, pc, ProgCtr);
    check({tag, ".run"}, {31'd0, run}, {31'd0, Running});
    check({tag, ".ack"}, {31'd0, ack}, {31'd0, Ack});
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; BranchEn = 1'b0; Equal = 1'b0; Halt = 1'b0; Offset = 5'd0;
    tick(); tick();
    check_st("reset", ProgCtr, Running, Ack);
    check("reset_pc", ProgCtr, 32'd0);
    check("reset_run", {31'd0, Running}, 32'd0);
    check("reset_ack", {31'd0, Ack}, 32'd0);

    // Hold in IDLE; decoder inputs must be ignored there.
    Reset = 1'b0; Start = 1'b1; BranchEn = 1'b1; Equal = 1'b1; Offset = 5'd5; Halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_pc", ProgCtr, 32'd0);
      check("idle_run", {31'd0, Running}, 32'd0);
    end

    Start = 1'b0; BranchEn = 1'b0; Equal = 1'b0; Halt = 1'b0; Offset = 5'd0;
    tick();
    check("first_run", {31'd0, Running}, 32'd1);
    check("first_pc", ProgCtr, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("inc_pc", ProgCtr, i);
    end

    BranchEn = 1'b1; Equal = 1'b1; Offset = 5'b11101;
    tick();
    check("br_back3", ProgCtr, 32'd5);
    Offset = 5'd3;
    tick();
    check("br_fwd3", ProgCtr, 32'd8);
    Equal = 1'b0; Offset = 5'b11101;
    tick();
    check("br_not_taken", ProgCtr, 32'd9);

    // Restart from RUN via Start.
    BranchEn = 1'b0; Start = 1'b1;
    tick();
    check("restart_pc", ProgCtr, 32'd0);
    check("restart_run", {31'd0, Running}, 32'd0);
    Start = 1'b0;
    tick();
    check("rerun_pc", ProgCtr, 32'd0);

    BranchEn = 1'b1; Equal = 1'b1; Offset = 5'b11111;
    tick();
    check("wrap_down", ProgCtr, 32'd1023);
    BranchEn = 1'b0;
    tick();
    check("wrap_up", ProgCtr, 32'd0);

    BranchEn = 1'b1; Equal = 1'b1; Offset = 5'd0;
    tick();
    check("self_loop", ProgCtr, 32'd0);
    Offset = 5'd15;
    tick();
    check("br_max_fwd", ProgCtr, 32'd15);
    Offset = 5'd5;
    tick();
    check("br_to_20", ProgCtr, 32'd20);

    // Halt beats a simultaneous taken branch.
    Halt = 1'b1;
    tick();
    check("halt_ack", {31'd0, Ack}, 32'd1);
    check("halt_run", {31'd0, Running}, 32'd0);
    check("halt_pc", ProgCtr, 32'd20);
    Halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_hold_pc", ProgCtr, 32'd20);
      check("halt_hold_ack", {31'd0, Ack}, 32'd1);
    end

    BranchEn = 1'b0; Equal = 1'b0; Start = 1'b1;
    tick();
    check("unhalt_pc", ProgCtr, 32'd0);
    check("unhalt_ack", {31'd0, Ack}, 32'd0);
    check("unhalt_run", {31'd0, Running}, 32'd0);
    Start = 1'b0;
    tick();
    check("run2", {31'd0, Running}, 32'd1);

    BranchEn = 1'b1; Equal = 1'b1; Offset = 5'd15;
    tick(); tick();
    Offset = 5'd7;
    tick();
    check("pc_37", ProgCtr, 32'd37);
    Reset = 1'b1;
    tick();
    check("midrst_pc", ProgCtr, 32'd0);
    check("midrst_run", {31'd0, Running}, 32'd0);
    check("midrst_ack", {31'd0, Ack}, 32'd0);
    Reset = 1'b0; BranchEn = 1'b0; Equal = 1'b0; Offset = 5'd0;
    tick();
    check("post_rst_run", {31'd0, Running}, 32'd1);
    check("post_rst_pc", ProgCtr, 32'd0);

`ifdef FETCH_CYCLE_COUNT_EN
    check("cc_first", {16'd0, CycleCount}, 32'd0);
    for (int i = 0; i < 11; i++) tick();
    check("cc_11", {16'd0, CycleCount}, 32'd11);
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    check("cc_halt", {16'd0, CycleCount}, 32'd12);
    tick(); tick();
    check("cc_frozen", {16'd0, CycleCount}, 32'd12);
    Start = 1'b1;
    tick();
    check("cc_clear", {16'd0, CycleCount}, 32'd0);
    Start = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
